// File: rtl/spi_bmm150_pkg.sv
// ---------------------------------------------------------------------------
// spi_bmm150_pkg
// Shared definitions for the BMM150-style SPI slave: FSM state encoding,
// register address/data widths and the read/write command bit value.
// ---------------------------------------------------------------------------
package spi_bmm150_pkg;

    localparam int   ADDR_W  = 7;
    localparam int   DATA_W  = 8;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for one asynchronous input bit.
// Every stage resets to 1, which is the idle level of sclk and cs_n.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input
//   o_q     - synchronized output (DEPTH clocks of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/spi_slave_bmm150.sv
// ---------------------------------------------------------------------------
// spi_slave_bmm150
// SPI mode-3 slave (MSB first) fronting a 128 x 8 register space.
// First byte of a frame: {rw, addr[6:0]}; following bytes are data, with the
// address auto-incrementing (mod 128) between bytes of a burst.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   sclk, cs_n, mosi    - SPI inputs from the master (asynchronous)
//   miso, miso_oe       - SPI read data and its drive enable
//   reg_addr            - register address of the current access
//   reg_re / reg_rdata  - read strobe; read data valid one clk later
//   reg_we / reg_wdata  - write strobe with write data
//   busy                - a frame is in progress
//   frame_err           - one-clk pulse when cs_n rises mid-byte
// ---------------------------------------------------------------------------
module spi_slave_bmm150
    import spi_bmm150_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [1:0] FLUSH_N = 2'(SYNC_STAGES);

    // ---------------- input synchronizers: bit 0 sclk, 1 cs_n, 2 mosi
    logic [2:0] w_raw;
    logic [2:0] w_sync;
    assign w_raw = {mosi, cs_n, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_d     (w_raw[gi]),
                .o_q     (w_sync[gi])
            );
        end
    endgenerate

    logic w_sclk_s, w_cs_s, w_mosi_s;
    assign w_sclk_s = w_sync[0];
    assign w_cs_s   = w_sync[1];
    assign w_mosi_s = w_sync[2];

    // ---------------- edge detection
    logic       r_sclk_d, r_cs_d;
    logic [1:0] r_flush_cnt;
    logic       r_armed;
    logic       w_flushed;
    logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    // The synchronizers come out of reset reading 1, so a cs_n that is
    // already low would look like a falling edge once they flush. Frames are
    // only accepted after cs_n has been seen high on real (flushed) samples.
    assign w_flushed   = (r_flush_cnt == FLUSH_N);
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d & r_armed;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
            r_flush_cnt <= 2'd0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            if (!w_flushed) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end
            if (w_flushed && w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ---------------- FSM
    state_t r_state, w_state_next;
    logic [2:0] r_bit_cnt;
    logic       w_last_bit;

    assign w_last_bit = w_sclk_rise && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = CMD;
            CMD:     if (w_cs_rise) w_state_next = IDLE;
                     else if (w_last_bit) w_state_next = DATA;
            DATA:    if (w_cs_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath
    logic [DATA_W-1:0] r_shift;
    logic              r_rw;
    logic              r_miso;
    logic              r_reg_re, r_reg_we, r_frame_err;
    logic              r_cap, r_cap_direct;
    logic              r_pend_inc;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_reg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_rw         <= 1'b0;
            r_miso       <= 1'b1;
            r_reg_re     <= 1'b0;
            r_reg_we     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cap        <= 1'b0;
            r_cap_direct <= 1'b0;
            r_pend_inc   <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
        end else begin
            r_reg_re    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_frame_err <= 1'b0;
            r_cap       <= r_reg_re;

            // A byte finishing in the same clk as cs_n rising is complete.
            if (w_cs_rise && r_state != IDLE && r_bit_cnt != 3'd0 && !w_last_bit) begin
                r_frame_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt  <= 3'd0;
                        r_pend_inc <= 1'b0;
                        r_miso     <= 1'b1;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        r_shift   <= {r_shift[DATA_W-2:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            // r_shift[6] is the first (rw) bit of the byte
                            r_rw         <= r_shift[6];
                            r_reg_addr   <= {r_shift[5:0], w_mosi_s};
                            r_miso       <= 1'b1;
                            r_cap_direct <= 1'b0;
                            if (r_shift[6] == RW_READ && !w_cs_rise) begin
                                r_reg_re <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_sclk_rise) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_rw != RW_READ) begin
                            r_shift <= {r_shift[DATA_W-2:0], w_mosi_s};
                        end
                        if (r_bit_cnt == 3'd7) begin
                            r_pend_inc <= 1'b1;
                            if (r_rw != RW_READ) begin
                                r_reg_we    <= 1'b1;
                                r_reg_wdata <= {r_shift[DATA_W-2:0], w_mosi_s};
                            end
                        end
                    end else if (w_sclk_fall) begin
                        if (r_pend_inc) begin
                            // First falling edge of a further burst byte: cs_n
                            // is still low, so move on and fetch the next read.
                            r_pend_inc <= 1'b0;
                            r_reg_addr <= r_reg_addr + 7'd1;
                            if (r_rw == RW_READ) begin
                                r_reg_re     <= 1'b1;
                                r_cap_direct <= 1'b1;
                            end
                        end else if (r_rw == RW_READ) begin
                            r_miso  <= r_shift[DATA_W-1];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase

            // Read data capture. For burst bytes the MSB's falling edge has
            // already passed, so it goes straight onto miso.
            if (r_cap) begin
                if (r_cap_direct) begin
                    r_miso  <= reg_rdata[DATA_W-1];
                    r_shift <= {reg_rdata[DATA_W-2:0], 1'b0};
                end else begin
                    r_shift <= reg_rdata;
                end
            end
        end
    end

    // ---------------- outputs
    logic w_rd_data;
    assign w_rd_data = (r_state == DATA) && (r_rw == RW_READ);

    assign miso      = w_rd_data ? r_miso : 1'b1;
    assign miso_oe   = w_rd_data;
    assign reg_addr  = r_reg_addr;
    assign reg_re    = r_reg_re;
    assign reg_we    = r_reg_we;
    assign reg_wdata = r_reg_wdata;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_bmm150.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_bmm150
// Directed and random SPI frames against spi_slave_bmm150. A mode-3 master
// task drives the bus; a read-only register stub answers reg_re; the
// expected strobe list and read bytes come from the frame description.
// ---------------------------------------------------------------------------
module tb_spi_slave_bmm150;

    localparam int H = 6;   // clk cycles per sclk half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [6:0] reg_addr;
    logic       reg_re, reg_we;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] reg_wdata;
    logic       busy, frame_err;

    spi_slave_bmm150 #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Read-only register stub: data valid the clk after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Strobe / error monitor
    int         ev_kind [$];   // 0 = read, 1 = write
    logic [6:0] ev_addr [$];
    logic [7:0] ev_data [$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (reg_re) begin
            ev_kind.push_back(0); ev_addr.push_back(reg_addr); ev_data.push_back(8'h00);
        end
        if (reg_we) begin
            ev_kind.push_back(1); ev_addr.push_back(reg_addr); ev_data.push_back(reg_wdata);
        end
        if (frame_err) ferr_cnt++;
        if (reg_re && reg_we) both_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        ev_kind.delete(); ev_addr.delete(); ev_data.delete();
        ferr_cnt = 0; both_cnt = 0;
    endtask

    task automatic cs_low();
        @(negedge clk) cs_n = 1'b0;
        clks(H);
    endtask

    task automatic cs_high();
        clks(H);
        cs_n = 1'b1;
        clks(12);
    endtask

    // Shift nbits MSB first; miso sampled at each master rising edge.
    // exp_oe < 0 skips the drive-enable check.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, input int exp_oe,
                             output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            mosi = tx[7-i];
            clks(H);
            rx[7-i] = miso;
            if (exp_oe >= 0) chk("miso_oe", {31'd0, miso_oe}, exp_oe);
            sclk = 1'b1;
            clks(H);
        end
    endtask

    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];

    task automatic do_frame(input logic rd, input logic [6:0] addr, input int n);
        logic [7:0] dummy;
        clear_log();
        cs_low();
        xfer_bits({rd, addr}, 8, 0, dummy);
        for (int b = 0; b < n; b++) begin
            xfer_bits(rd ? 8'hFF : tx_buf[b], 8, rd ? 1 : 0, rx_buf[b]);
        end
        cs_high();
        $display("frame %s addr=0x%02h bytes=%0d strobes=%0d", rd ? "read " : "write",
                 addr, n, ev_kind.size());
    endtask

    // Expected: one strobe per byte at addr+i (mod 128); reads return mem.
    task automatic check_frame(input string tag, input logic rd, input logic [6:0] addr,
                               input int n);
        logic [6:0] a;
        chk({tag, " strobes"}, ev_kind.size(), n);
        for (int i = 0; i < n && i < ev_kind.size(); i++) begin
            a = addr + 7'(i);
            chk({tag, " kind"}, ev_kind[i], rd ? 0 : 1);
            chk({tag, " addr"}, {25'd0, ev_addr[i]}, {25'd0, a});
            if (rd) chk({tag, " rx"}, {24'd0, rx_buf[i]}, {24'd0, mem[a]});
            else    chk({tag, " wdata"}, {24'd0, ev_data[i]}, {24'd0, tx_buf[i]});
        end
        chk({tag, " frame_err"}, ferr_cnt, 0);
        chk({tag, " re_we"}, both_cnt, 0);
        chk({tag, " idle_oe"}, {31'd0, miso_oe}, 0);
        chk({tag, " idle_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " miso"},      {31'd0, miso}, 1);
        chk({tag, " miso_oe"},   {31'd0, miso_oe}, 0);
        chk({tag, " reg_addr"},  {25'd0, reg_addr}, 0);
        chk({tag, " reg_wdata"}, {24'd0, reg_wdata}, 0);
        chk({tag, " reg_re"},    {31'd0, reg_re}, 0);
        chk({tag, " reg_we"},    {31'd0, reg_we}, 0);
        chk({tag, " busy"},      {31'd0, busy}, 0);
        chk({tag, " frame_err"}, {31'd0, frame_err}, 0);
    endtask

    initial begin
        logic [7:0] dummy;
        logic       rd;
        logic [6:0] addr;
        int         n;

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h40] = 8'h32;
        mem[7'h42] = 8'h10;
        mem[7'h43] = 8'h11;
        mem[7'h44] = 8'h12;

        // Reset state
        clks(5);
        check_reset_vals("reset");
        rst_n = 1'b1;
        clks(10);

        // Single write 0x4B <- 0x01
        tx_buf[0] = 8'h01;
        do_frame(1'b0, 7'h4B, 1);
        check_frame("wr4B", 1'b0, 7'h4B, 1);

        // Single read 0x40 -> 0x32
        do_frame(1'b1, 7'h40, 1);
        check_frame("rd40", 1'b1, 7'h40, 1);
        chk("rd40 byte", {24'd0, rx_buf[0]}, 32'h32);

        // Burst read 0x42..0x44
        do_frame(1'b1, 7'h42, 3);
        check_frame("burst_rd", 1'b1, 7'h42, 3);
        chk("burst_rd b2", {24'd0, rx_buf[2]}, 32'h12);

        // Burst write wrapping 0x7F -> 0x00
        tx_buf[0] = 8'hAA; tx_buf[1] = 8'h55;
        do_frame(1'b0, 7'h7F, 2);
        check_frame("wrap_wr", 1'b0, 7'h7F, 2);

        // Abort after 4 data bits
        clear_log();
        cs_low();
        xfer_bits({1'b0, 7'h4C}, 8, 0, dummy);
        xfer_bits(8'hA5, 4, 0, dummy);
        cs_high();
        $display("frame abort addr=0x4c bits=4 strobes=%0d frame_err=%0d", ev_kind.size(), ferr_cnt);
        chk("abort strobes", ev_kind.size(), 0);
        chk("abort frame_err", ferr_cnt, 1);
        tx_buf[0] = 8'h07;
        do_frame(1'b0, 7'h4C, 1);
        check_frame("after_abort", 1'b0, 7'h4C, 1);

        // Reset during the address phase, cs_n held low across release
        clear_log();
        cs_low();
        xfer_bits({1'b0, 7'h4B}, 4, 0, dummy);
        @(negedge clk) rst_n = 1'b0;
        clks(3);
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        clks(10);
        xfer_bits({1'b0, 7'h10}, 8, -1, dummy);
        xfer_bits(8'h99, 8, -1, dummy);
        cs_high();
        $display("frame no-cs-edge addr=0x10 strobes=%0d", ev_kind.size());
        chk("no_edge strobes", ev_kind.size(), 0);
        chk("no_edge frame_err", ferr_cnt, 0);
        chk("no_edge busy", {31'd0, busy}, 0);
        tx_buf[0] = 8'h99;
        do_frame(1'b0, 7'h10, 1);
        check_frame("after_reset", 1'b0, 7'h10, 1);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            rd   = 1'($urandom);
            addr = 7'($urandom);
            n    = $urandom_range(1, 3);
            for (int b = 0; b < 4; b++) tx_buf[b] = 8'($urandom);
            do_frame(rd, addr, n);
            check_frame("random", rd, addr, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
